ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch unit: the requester side of the instruction-memory read port.
- Holds the PC and drives the word address to instruction memory.
- Captures the returned instruction into the F/D pipeline register.
- Applies stall and redirect (branch/jump/exception target) from downstream stages.
- Detects illegal fetch addresses and parks in a fault state until redirected.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset and base of the instruction space.
- IM_WORDS, 4096, instruction-memory depth in 32-bit words; legal range is PC_RESET to PC_RESET+4*IM_WORDS-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- f_pc  output  32  current fetch address to instruction memory; equals the PC register.
- f_instr  input  32  instruction word returned combinationally for f_pc.
- stall  input  1  hazard unit: hold PC and F/D register.
- redirect_valid  input  1  load redirect_target as next PC.
- redirect_target  input  32  new PC (branch/jump/exception entry).
- d_instr  output  32  F/D register: instruction.
- d_pc  output  32  F/D register: PC of d_instr.
- d_pc8  output  32  F/D register: d_pc+8, the link value.
- d_valid  output  1  F/D register holds a real instruction.
- fetch_fault  output  1  high while in FAULT state.

Behaviour:
- Reset (rst_n=0, async):
  - PC=PC_RESET, so f_pc=PC_RESET.
  - d_instr=0, d_pc=PC_RESET, d_pc8=PC_RESET+8, d_valid=0.
  - State=RUN, fetch_fault=0.
- Reset release: the first instruction is captured into F/D at the first rising edge with rst_n=1 and stall=0.
- Latency: f_pc is registered (no combinational path from any input to f_pc). f_instr appears on d_instr one edge after f_pc is presented.
- fetch_err (combinational, internal) is asserted when either:
  - f_pc[1:0]!=0, or
  - f_pc<PC_RESET or f_pc>=PC_RESET+4*IM_WORDS (compared with 32-bit unsigned arithmetic, no wrap).
- FSM has two states, RUN and FAULT.
- RUN, stall=1:
  - PC, F/D and state hold. redirect_valid is ignored; the source must keep it asserted until the stall drops.
- RUN, stall=0, fetch_err=0:
  - F/D <= {f_instr, f_pc, f_pc+8, valid=1}.
  - PC <= redirect_valid ? redirect_target : f_pc+4.
- RUN, stall=0, fetch_err=1:
  - F/D <= {0, f_pc, f_pc+8, valid=0}.
  - If redirect_valid: PC <= redirect_target and stay RUN.
  - Otherwise: PC holds and state -> FAULT.
- FAULT:
  - fetch_fault=1; d_valid=0, d_instr=0; PC held; stall ignored.
  - redirect_valid=1: PC <= redirect_target, state -> RUN, fetch_fault=0 from the next cycle.
- Delay slot: a redirect does not flush. The instruction fetched in the same cycle as the redirect enters F/D normally as the delay slot.
- Arithmetic: PC+4 and PC+8 are 32-bit modulo; overflow is caught by the range check on the next fetch.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of stall or redirect.

Test Plan:
- Reset then 4 free-running cycles with IM returning 0xA0000000+index → f_pc 0x3000,0x3004,0x3008,0x300C; d_instr/d_pc lag by one edge; d_pc8=d_pc+8; d_valid 0 then 1.
- stall=1 for 2 cycles at PC=0x3008 → f_pc and F/D frozen; resumes at 0x300C after release; no instruction duplicated or skipped.
- redirect_valid=1, target=0x3100 at f_pc=0x3010 → 0x3010 (delay slot) enters F/D; next f_pc=0x3100; stall+redirect together → redirect taken only after stall drops.
- redirect to 0x3102 (misaligned) → next edge: d_valid=0, fetch_fault=1, f_pc stays 0x3102. redirect to 0x3000 → fetch_fault=0, normal fetch resumes.
- redirect to 0x7000 and to 0x2FFC → fault each time; 0x6FFC → legal fetch.
- Assert rst_n=0 mid-stall while in FAULT → immediately f_pc=0x3000, d_valid=0, fetch_fault=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: the requester side of the instruction-memory read port.
// It holds the PC, presents it to instruction memory, and captures the
// returned word into the F/D pipeline register. It also applies stall and
// redirect requests from later stages. An illegal fetch address (misaligned
// or outside the instruction space) parks the unit in FAULT until a
// redirect arrives.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   f_pc             fetch address to instruction memory (the PC register)
//   f_instr          instruction word returned combinationally for f_pc
//   stall            hold PC and F/D (ignored while in FAULT)
//   redirect_valid   load redirect_target as the next PC
//   redirect_target  branch/jump/exception target
//   d_instr, d_pc, d_pc8, d_valid   F/D pipeline register
//   fetch_fault      high while parked in FAULT
//
// State | Meaning
// RUN   | normal fetch; F/D is updated every unstalled cycle
// FAULT | the last fetch address was illegal; PC is held until a redirect
module ifu_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] f_pc,
    input  logic [31:0] f_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid,
    output logic        fetch_fault
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    // The end of the space is computed in 33 bits so that a space that
    // ends exactly at 2^32 does not wrap to zero.
    localparam logic [32:0] PC_END = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] d_instr_q;
    logic [31:0] d_pc_q;
    logic [31:0] d_pc8_q;
    logic        d_valid_q;
    logic        fault_q;
    logic        fetch_err;

    assign fetch_err = (pc_q[1:0] != 2'b00)
                    || (pc_q < PC_RESET)
                    || ({1'b0, pc_q} >= PC_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= PC_RESET;
            d_instr_q <= 32'd0;
            d_pc_q    <= PC_RESET;
            d_pc8_q   <= PC_RESET + 32'd8;
            d_valid_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        // F/D always records the fetch address, even when
                        // the fetch is illegal, so the fault PC is visible.
                        d_pc_q  <= pc_q;
                        d_pc8_q <= pc_q + 32'd8;
                        if (!fetch_err) begin
                            d_instr_q <= f_instr;
                            d_valid_q <= 1'b1;
                            pc_q      <= redirect_valid ? redirect_target
                                                        : pc_q + 32'd4;
                        end else begin
                            d_instr_q <= 32'd0;
                            d_valid_q <= 1'b0;
                            if (redirect_valid) begin
                                pc_q <= redirect_target;
                            end else begin
                                state_q <= FAULT;
                                fault_q <= 1'b1;
                            end
                        end
                    end
                end
                FAULT: begin
                    d_instr_q <= 32'd0;
                    d_valid_q <= 1'b0;
                    if (redirect_valid) begin
                        pc_q    <= redirect_target;
                        state_q <= RUN;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign f_pc        = pc_q;
    assign d_instr     = d_instr_q;
    assign d_pc        = d_pc_q;
    assign d_pc8       = d_pc8_q;
    assign d_valid     = d_valid_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        d_valid;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    ifu_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .f_pc            (f_pc),
        .f_instr         (f_instr),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .d_instr         (d_instr),
        .d_pc            (d_pc),
        .d_pc8           (d_pc8),
        .d_valid         (d_valid),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word index tagged with 0xA0000000.
    function automatic logic [31:0] im(input logic [31:0] a);
        return 32'hA000_0000 + ((a - 32'h0000_3000) >> 2);
    endfunction

    assign f_instr = im(f_pc);

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] e_fpc;
        logic [31:0] e_instr;
        logic [31:0] e_dpc;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                                input logic [31:0] fpc, input logic [31:0] ins,
                                input logic [31:0] dpc, input logic v, input logic f);
        vec_t x;
        x.stall = s; x.rv = r; x.tgt = t;
        x.e_fpc = fpc; x.e_instr = ins; x.e_dpc = dpc; x.e_valid = v; x.e_fault = f;
        return x;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] fpc, input logic [31:0] ins,
                           input logic [31:0] dpc, input logic v, input logic f);
        chk32({tag, ".f_pc"}, f_pc, fpc);
        chk32({tag, ".d_instr"}, d_instr, ins);
        chk32({tag, ".d_pc"}, d_pc, dpc);
        chk32({tag, ".d_pc8"}, d_pc8, dpc + 32'd8);
        chk1({tag, ".d_valid"}, d_valid, v);
        chk1({tag, ".fetch_fault"}, fetch_fault, f);
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] t);
        stall = s;
        redirect_valid = r;
        redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    // Reference model state, updated by the fetch-unit rules.
    logic [31:0] m_pc, m_instr, m_dpc;
    logic        m_valid, m_fault;

    function automatic logic illegal(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (a % 4 != 0) || (la < 64'h3000) || (la >= 64'h3000 + 4 * 4096);
    endfunction

    task automatic model_reset();
        m_pc = 32'h3000; m_instr = 0; m_dpc = 32'h3000; m_valid = 0; m_fault = 0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] t);
        if (m_fault) begin
            m_instr = 0; m_valid = 0;
            if (r) begin m_pc = t; m_fault = 0; end
        end else if (!s) begin
            m_dpc = m_pc;
            if (!illegal(m_pc)) begin
                m_instr = im(m_pc); m_valid = 1;
                m_pc = r ? t : m_pc + 4;
            end else begin
                m_instr = 0; m_valid = 0;
                if (r) m_pc = t; else m_fault = 1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        #12;
        chk_all("reset", 32'h3000, 32'h0, 32'h3000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //              stall rv  tgt           f_pc          d_instr       d_pc          v  f
        vecs.push_back(mk(0, 0, 32'h0,        32'h3004, 32'hA0000000, 32'h3000, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'h3008, 32'hA0000001, 32'h3004, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,        32'h3008, 32'hA0000001, 32'h3004, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,        32'h3008, 32'hA0000001, 32'h3004, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'h300C, 32'hA0000002, 32'h3008, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'h3010, 32'hA0000003, 32'h300C, 1, 0));
        vecs.push_back(mk(0, 1, 32'h3100,     32'h3100, 32'hA0000004, 32'h3010, 1, 0));
        vecs.push_back(mk(1, 1, 32'h3200,     32'h3100, 32'hA0000004, 32'h3010, 1, 0));
        vecs.push_back(mk(0, 1, 32'h3200,     32'h3200, 32'hA0000040, 32'h3100, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'h3204, 32'hA0000080, 32'h3200, 1, 0));
        vecs.push_back(mk(0, 1, 32'h3102,     32'h3102, 32'hA0000081, 32'h3204, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'h3102, 32'h0,        32'h3102, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        32'h3102, 32'h0,        32'h3102, 0, 1));
        vecs.push_back(mk(1, 0, 32'h0,        32'h3102, 32'h0,        32'h3102, 0, 1));
        vecs.push_back(mk(1, 1, 32'h3000,     32'h3000, 32'h0,        32'h3102, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'h3004, 32'hA0000000, 32'h3000, 1, 0));
        vecs.push_back(mk(0, 1, 32'h7000,     32'h7000, 32'hA0000001, 32'h3004, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'h7000, 32'h0,        32'h7000, 0, 1));
        vecs.push_back(mk(0, 1, 32'h2FFC,     32'h2FFC, 32'h0,        32'h7000, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'h2FFC, 32'h0,        32'h2FFC, 0, 1));
        vecs.push_back(mk(0, 1, 32'h6FFC,     32'h6FFC, 32'h0,        32'h2FFC, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'h7000, 32'hA0000FFF, 32'h6FFC, 1, 0));
        vecs.push_back(mk(0, 1, 32'h3010,     32'h3010, 32'h0,        32'h7000, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'h3014, 32'hA0000004, 32'h3010, 1, 0));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hA0000005, 32'h3014, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        32'hFFFFFFFC, 32'h0,    32'hFFFFFFFC, 0, 1));
        vecs.push_back(mk(1, 0, 32'h0,        32'hFFFFFFFC, 32'h0,    32'hFFFFFFFC, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].stall, vecs[i].rv, vecs[i].tgt);
            chk_all($sformatf("vec%0d", i), vecs[i].e_fpc, vecs[i].e_instr,
                    vecs[i].e_dpc, vecs[i].e_valid, vecs[i].e_fault);
        end

        // Asynchronous reset while stalled in FAULT, mid-cycle.
        stall = 1'b1;
        redirect_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midreset", 32'h3000, 32'h0, 32'h3000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        model_reset();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic        s, r;
            logic [31:0] t;
            int          k;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 5) == 0);
            k = $urandom_range(0, 9);
            if (k < 7)       t = 32'h3000 + 4 * $urandom_range(0, 4095);
            else if (k == 7) t = 32'h3000 + $urandom_range(0, 16383);
            else if (k == 8) t = 32'h6FF0 + 4 * $urandom_range(0, 7);
            else             t = $urandom;
            model_step(s, r, t);
            step(s, r, t);
            chk_all($sformatf("rand%0d", n), m_pc, m_instr, m_dpc, m_valid, m_fault);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
